// File: rtl/ht_request_arbiter_if.sv
// Packed command/response bus between NUM_REQ requesters, the arbiter and the hash table.
// The arbiter takes the slave view; the requesters plus table model take the master view.
interface ht_request_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int KEY_WIDTH  = 4,
    parameter int DATA_WIDTH = 26
);
    localparam int W = 2 + KEY_WIDTH + DATA_WIDTH;

    logic [NUM_REQ*W-1:0] req_data_i;
    logic [NUM_REQ-1:0]   req_valid_i;
    logic [NUM_REQ-1:0]   req_ready_o;
    logic [W-1:0]         rsp_data_o;
    logic [NUM_REQ-1:0]   rsp_valid_o;
    logic [NUM_REQ-1:0]   rsp_ready_i;
    logic [W-1:0]         tbl_data_o;
    logic                 tbl_valid_o;
    logic                 tbl_ready_i;
    logic [W-1:0]         tbl_data_i;
    logic                 tbl_valid_i;
    logic                 tbl_ready_o;
    logic                 orphan_o;

    modport slave (
        input  req_data_i, req_valid_i, rsp_ready_i, tbl_ready_i, tbl_data_i, tbl_valid_i,
        output req_ready_o, rsp_data_o, rsp_valid_o, tbl_data_o, tbl_valid_o, tbl_ready_o,
               orphan_o
    );

    modport master (
        output req_data_i, req_valid_i, rsp_ready_i, tbl_ready_i, tbl_data_i, tbl_valid_i,
        input  req_ready_o, rsp_data_o, rsp_valid_o, tbl_data_o, tbl_valid_o, tbl_ready_o,
               orphan_o
    );
endinterface

// File: rtl/ht_request_arbiter.sv
// Round-robin arbiter sharing one hash table between NUM_REQ requesters, with in-order tag
// FIFO for response routing. Define HT_ARB_PRIORITY_EN to give requester 0 strict priority.
module ht_request_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int KEY_WIDTH       = 4,
    parameter int DATA_WIDTH      = 26,
    parameter int MAX_OUTSTANDING = 4
) (
    input logic                 clk,
    input logic                 reset,
    ht_request_arbiter_if.slave bus
);
    localparam int W  = 2 + KEY_WIDTH + DATA_WIDTH;
    localparam int IW = $clog2(NUM_REQ);
    localparam int AW = $clog2(MAX_OUTSTANDING);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [1:0]            op;
        logic [KEY_WIDTH-1:0]  key;
        logic [DATA_WIDTH-1:0] data;
    } cmd_t;

    logic [NUM_REQ-1:0][W-1:0] req_word;
    assign req_word = bus.req_data_i;

    cmd_t    issue_q;
    logic    issue_vld;
    logic [IW-1:0] rr_ptr;
    logic [CW-1:0] count;

    logic [MAX_OUTSTANDING-1:0][IW-1:0] tag_mem;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [IW-1:0] head;

    logic          can_accept, req_any, grant, rr_upd, tags_empty, rsp_live, pop;
    logic [IW-1:0] grant_idx, rr_next;

    // Comb outputs are forced quiet while reset is held so nothing is granted or flagged.
    assign can_accept = reset && (!issue_vld || bus.tbl_ready_i)
                        && (count < CW'(MAX_OUTSTANDING));

    always_comb begin : arb
        int idx;
        idx       = 0;
        req_any   = 1'b0;
        grant_idx = '0;
        rr_upd    = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!req_any && bus.req_valid_i[idx]) begin
                req_any   = 1'b1;
                grant_idx = IW'(idx);
            end
        end
`ifdef HT_ARB_PRIORITY_EN
        // Requester 0 pre-empts the rotation and leaves the pointer where it was.
        if (bus.req_valid_i[0]) begin
            req_any   = 1'b1;
            grant_idx = '0;
            rr_upd    = 1'b0;
        end
`endif
    end

    assign grant   = can_accept && req_any;
    assign rr_next = (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    // The tag FIFO occupancy always equals count, so count doubles as the empty flag.
    assign tags_empty      = (count == '0);
    assign head            = tag_mem[rd_ptr];
    assign rsp_live        = bus.tbl_valid_i && !tags_empty;
    assign bus.tbl_ready_o = tags_empty ? 1'b1 : bus.rsp_ready_i[head];
    assign pop             = rsp_live && bus.tbl_ready_o;
    assign bus.rsp_data_o  = bus.tbl_data_i;
    assign bus.orphan_o    = reset && tags_empty && bus.tbl_valid_i;

    assign bus.tbl_data_o  = issue_q;
    assign bus.tbl_valid_o = issue_vld;

    for (genvar r = 0; r < NUM_REQ; r++) begin : g_lane
        assign bus.req_ready_o[r] = grant && (grant_idx == IW'(r));
        assign bus.rsp_valid_o[r] = rsp_live && (head == IW'(r));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            issue_q   <= '0;
            issue_vld <= 1'b0;
            rr_ptr    <= '0;
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
        end else begin
            if (grant) begin
                issue_q   <= cmd_t'(req_word[grant_idx]);
                issue_vld <= 1'b1;
                wr_ptr    <= wr_ptr + 1'b1;
                if (rr_upd) rr_ptr <= rr_next;
            end else if (bus.tbl_ready_i) begin
                issue_vld <= 1'b0;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({grant, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Tag storage needs no reset: entries are only read between a push and its pop.
    always_ff @(posedge clk) begin
        if (grant) tag_mem[wr_ptr] <= grant_idx;
    end
endmodule

// File: tb/tb_ht_request_arbiter.sv
// Directed bench for ht_request_arbiter: per-cycle vector table plus hand-written sequences.
module tb_ht_request_arbiter;
    localparam int NR = 4;
`ifdef HT_ARB_PRIORITY_EN
    localparam bit PRI = 1'b1;
`else
    localparam bit PRI = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ht_request_arbiter_if #(.NUM_REQ(NR), .KEY_WIDTH(4), .DATA_WIDTH(26)) bus ();

    ht_request_arbiter #(.NUM_REQ(NR), .KEY_WIDTH(4), .DATA_WIDTH(26), .MAX_OUTSTANDING(4)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    typedef struct {
        logic [3:0]  rv;
        logic [3:0]  rr;
        logic        tr;
        logic        tv;
        logic [31:0] td;
        logic [3:0]  gnt;
        logic        ov;
        logic [31:0] od;
        logic [3:0]  rspv;
        logic        tro;
        logic        orph;
    } vec_t;

    int n_chk = 0, n_pass = 0;
    logic [3:0] last_gnt;
    vec_t tbl[$];

    function automatic logic [31:0] wd(int r);
        logic [3:0]  k;
        logic [25:0] d;
        k = 4'(r + 3);
        d = 26'(32'h121 + r);
        return {2'b01, k, d};
    endfunction

    function automatic logic [31:0] rw(int n);
        return 32'h8000_0A00 + 32'(n);
    endfunction

    function automatic vec_t mk(logic [3:0] rv, logic [3:0] rr, logic tr, logic tv,
                                logic [31:0] td, logic [3:0] gnt, logic ov, logic [31:0] od,
                                logic [3:0] rspv, logic tro, logic orph);
        vec_t v;
        v.rv = rv; v.rr = rr; v.tr = tr; v.tv = tv; v.td = td;
        v.gnt = gnt; v.ov = ov; v.od = od; v.rspv = rspv; v.tro = tro; v.orph = orph;
        return v;
    endfunction

    function automatic vec_t idle();
        return mk(4'b0, 4'hF, 1'b1, 1'b0, 32'h0, 4'b0, 1'b0, 32'h0, 4'b0, 1'b1, 1'b0);
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Inputs applied just after a rising edge; outputs compared on the falling edge.
    task automatic step(vec_t v, string nm);
        bus.req_valid_i = v.rv;
        bus.rsp_ready_i = v.rr;
        bus.tbl_ready_i = v.tr;
        bus.tbl_valid_i = v.tv;
        bus.tbl_data_i  = v.td;
        @(negedge clk);
        last_gnt = bus.req_ready_o;
        chk({nm, ".req_ready"}, 32'(bus.req_ready_o), 32'(v.gnt));
        chk({nm, ".tbl_valid"}, 32'(bus.tbl_valid_o), 32'(v.ov));
        if (v.ov) chk({nm, ".tbl_data"}, bus.tbl_data_o, v.od);
        chk({nm, ".rsp_valid"}, 32'(bus.rsp_valid_o), 32'(v.rspv));
        if (v.rspv != 4'b0) chk({nm, ".rsp_data"}, bus.rsp_data_o, v.td);
        chk({nm, ".tbl_ready"}, 32'(bus.tbl_ready_o), 32'(v.tro));
        chk({nm, ".orphan"}, 32'(bus.orphan_o), 32'(v.orph));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt[NR];
        int e1, e2, ei;
        logic [3:0] oh1, oh2, ohi;

        // Single request, routing, orphan, backpressure, outstanding limit.
        tbl.push_back(mk(4'b0100, 4'hF, 1, 0, 0,      4'b0100, 0, 0,      4'b0,    1, 0));
        tbl.push_back(mk(4'b0000, 4'hF, 1, 0, 0,      4'b0000, 1, wd(2),  4'b0,    1, 0));
        tbl.push_back(idle());
        tbl.push_back(idle());
        tbl.push_back(mk(4'b0000, 4'hF, 1, 1, wd(2),  4'b0000, 0, 0,      4'b0100, 1, 0));
        tbl.push_back(idle());
        tbl.push_back(mk(4'b1000, 4'hF, 1, 0, 0,      4'b1000, 0, 0,      4'b0,    1, 0));
        tbl.push_back(mk(4'b0010, 4'hF, 1, 0, 0,      4'b0010, 1, wd(3),  4'b0,    1, 0));
        tbl.push_back(mk(4'b1000, 4'hF, 1, 0, 0,      4'b1000, 1, wd(1),  4'b0,    1, 0));
        tbl.push_back(mk(4'b0000, 4'hD, 1, 1, rw(0),  4'b0000, 1, wd(3),  4'b1000, 1, 0));
        tbl.push_back(mk(4'b0000, 4'hD, 1, 1, rw(1),  4'b0000, 0, 0,      4'b0010, 0, 0));
        tbl.push_back(mk(4'b0000, 4'hD, 1, 1, rw(1),  4'b0000, 0, 0,      4'b0010, 0, 0));
        tbl.push_back(mk(4'b0000, 4'hF, 1, 1, rw(1),  4'b0000, 0, 0,      4'b0010, 1, 0));
        tbl.push_back(mk(4'b0000, 4'hF, 1, 1, rw(2),  4'b0000, 0, 0,      4'b1000, 1, 0));
        tbl.push_back(idle());
        tbl.push_back(mk(4'b0000, 4'hF, 1, 1, rw(15), 4'b0000, 0, 0,      4'b0,    1, 1));
        tbl.push_back(idle());
        tbl.push_back(mk(4'b0001, 4'hF, 0, 0, 0,      4'b0001, 0, 0,      4'b0,    1, 0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(4'b0010, 4'hF, 0, 0, 0,  4'b0000, 1, wd(0),  4'b0,    1, 0));
        tbl.push_back(mk(4'b0010, 4'hF, 1, 0, 0,      4'b0010, 1, wd(0),  4'b0,    1, 0));
        tbl.push_back(mk(4'b0000, 4'hF, 1, 0, 0,      4'b0000, 1, wd(1),  4'b0,    1, 0));
        tbl.push_back(mk(4'b0000, 4'hF, 1, 1, rw(3),  4'b0000, 0, 0,      4'b0001, 1, 0));
        tbl.push_back(mk(4'b0000, 4'hF, 1, 1, rw(4),  4'b0000, 0, 0,      4'b0010, 1, 0));
        tbl.push_back(idle());
        tbl.push_back(mk(4'b1110, 4'hF, 1, 0, 0,      4'b0100, 0, 0,      4'b0,    1, 0));
        tbl.push_back(mk(4'b1110, 4'hF, 1, 0, 0,      4'b1000, 1, wd(2),  4'b0,    1, 0));
        tbl.push_back(mk(4'b1110, 4'hF, 1, 0, 0,      4'b0010, 1, wd(3),  4'b0,    1, 0));
        tbl.push_back(mk(4'b1110, 4'hF, 1, 0, 0,      4'b0100, 1, wd(1),  4'b0,    1, 0));
        tbl.push_back(mk(4'b1110, 4'hF, 1, 0, 0,      4'b0000, 1, wd(2),  4'b0,    1, 0));
        tbl.push_back(mk(4'b1110, 4'hF, 1, 0, 0,      4'b0000, 0, 0,      4'b0,    1, 0));
        tbl.push_back(mk(4'b1110, 4'hF, 1, 0, 0,      4'b0000, 0, 0,      4'b0,    1, 0));
        tbl.push_back(mk(4'b1110, 4'hF, 1, 1, rw(5),  4'b0000, 0, 0,      4'b0100, 1, 0));
        tbl.push_back(mk(4'b1110, 4'hF, 1, 0, 0,      4'b1000, 0, 0,      4'b0,    1, 0));
        tbl.push_back(mk(4'b0000, 4'hF, 1, 0, 0,      4'b0000, 1, wd(3),  4'b0,    1, 0));
        tbl.push_back(mk(4'b0000, 4'hF, 1, 1, rw(6),  4'b0000, 0, 0,      4'b1000, 1, 0));
        tbl.push_back(mk(4'b0000, 4'hF, 1, 1, rw(7),  4'b0000, 0, 0,      4'b0010, 1, 0));
        tbl.push_back(mk(4'b0000, 4'hF, 1, 1, rw(8),  4'b0000, 0, 0,      4'b0100, 1, 0));
        tbl.push_back(mk(4'b0000, 4'hF, 1, 1, rw(9),  4'b0000, 0, 0,      4'b1000, 1, 0));
        tbl.push_back(idle());

        for (int r = 0; r < NR; r++) bus.req_data_i[r*32 +: 32] = wd(r);
        reset = 1'b0;
        bus.req_valid_i = 4'hF;
        bus.rsp_ready_i = 4'hF;
        bus.tbl_ready_i = 1'b1;
        bus.tbl_valid_i = 1'b1;
        bus.tbl_data_i  = rw(99);
        #2;
        chk("rst.tbl_valid", 32'(bus.tbl_valid_o), 32'd0);
        chk("rst.tbl_data", bus.tbl_data_o, 32'd0);
        chk("rst.req_ready", 32'(bus.req_ready_o), 32'd0);
        chk("rst.rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        chk("rst.orphan", 32'(bus.orphan_o), 32'd0);
        @(negedge clk);
        bus.req_valid_i = 4'b0;
        bus.tbl_valid_i = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

        // Fairness: everyone asks every cycle; table answers two cycles after each grant.
        for (int r = 0; r < NR; r++) cnt[r] = 0;
        e1 = -1; e2 = -1;
        for (int k = 0; k < 103; k++) begin
            ei  = (k < 100) ? (PRI ? 0 : k % 4) : -1;
            ohi = (ei >= 0) ? 4'(1 << ei) : 4'b0;
            oh1 = (e1 >= 0) ? 4'(1 << e1) : 4'b0;
            oh2 = (e2 >= 0) ? 4'(1 << e2) : 4'b0;
            step(mk((k < 100) ? 4'hF : 4'h0, 4'hF, 1, (e2 >= 0), rw(100 + k),
                    ohi, (e1 >= 0), (e1 >= 0) ? wd(e1) : 32'h0, oh2, 1, 0),
                 $sformatf("fair%0d", k));
            for (int r = 0; r < NR; r++) if (last_gnt[r]) cnt[r]++;
            if (oh1 == 4'b0 && e1 >= 0) e1 = -1;
            e2 = e1;
            e1 = ei;
        end
        for (int r = 0; r < NR; r++)
            chk($sformatf("fair.grants%0d", r), 32'(cnt[r]), PRI ? ((r == 0) ? 32'd100 : 32'd0) : 32'd25);

        // Reset with two tags outstanding; later responses become orphans.
        step(mk(4'b0001, 4'hF, 1, 0, 0, 4'b0001, 0, 0,     4'b0, 1, 0), "ro0");
        step(mk(4'b0010, 4'hF, 1, 0, 0, 4'b0010, 1, wd(0), 4'b0, 1, 0), "ro1");
        reset = 1'b0;
        bus.req_valid_i = 4'hF;
        bus.tbl_valid_i = 1'b1;
        bus.tbl_data_i  = rw(20);
        #1;
        chk("midrst.tbl_valid", 32'(bus.tbl_valid_o), 32'd0);
        chk("midrst.tbl_data", bus.tbl_data_o, 32'd0);
        chk("midrst.req_ready", 32'(bus.req_ready_o), 32'd0);
        chk("midrst.rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        @(negedge clk);
        bus.req_valid_i = 4'b0;
        bus.tbl_valid_i = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        step(mk(4'b0, 4'hF, 1, 1, rw(21), 4'b0, 0, 0, 4'b0, 1, 1), "orph0");
        step(mk(4'b0, 4'hF, 1, 1, rw(22), 4'b0, 0, 0, 4'b0, 1, 1), "orph1");
        step(idle(), "orph_end");

        // count must be back at zero: exactly four grants fit again.
        step(mk(4'b1110, 4'hF, 1, 0, 0, 4'b0010, 0, 0,     4'b0, 1, 0), "cnt0");
        step(mk(4'b1110, 4'hF, 1, 0, 0, 4'b0100, 1, wd(1), 4'b0, 1, 0), "cnt1");
        step(mk(4'b1110, 4'hF, 1, 0, 0, 4'b1000, 1, wd(2), 4'b0, 1, 0), "cnt2");
        step(mk(4'b1110, 4'hF, 1, 0, 0, 4'b0010, 1, wd(3), 4'b0, 1, 0), "cnt3");
        step(mk(4'b1110, 4'hF, 1, 0, 0, 4'b0000, 1, wd(1), 4'b0, 1, 0), "cnt4");
        step(mk(4'b0, 4'hF, 1, 1, rw(23), 4'b0, 0, 0, 4'b0010, 1, 0), "drn0");
        step(mk(4'b0, 4'hF, 1, 1, rw(24), 4'b0, 0, 0, 4'b0100, 1, 0), "drn1");
        step(mk(4'b0, 4'hF, 1, 1, rw(25), 4'b0, 0, 0, 4'b1000, 1, 0), "drn2");
        step(mk(4'b0, 4'hF, 1, 1, rw(26), 4'b0, 0, 0, 4'b0010, 1, 0), "drn3");

        // rr_ptr is 2 here: requester 2 wins round-robin, requester 0 wins with priority.
        step(mk(4'b0101, 4'hF, 1, 0, 0, PRI ? 4'b0001 : 4'b0100, 0, 0, 4'b0, 1, 0), "pri0");
        step(mk(4'b0, 4'hF, 1, 0, 0, 4'b0, 1, PRI ? wd(0) : wd(2), 4'b0, 1, 0), "pri1");
        step(mk(4'b0, 4'hF, 1, 1, rw(27), 4'b0, 0, 0, PRI ? 4'b0001 : 4'b0100, 1, 0), "pri2");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ht_request_arbiter.md
Name: ht_request_arbiter

Overview:
- Shares one hash_table instance between NUM_REQ independent requesters.
- Each requester uses the same packed command word as the hash table's packed wrapper port: {op[1:0], key, data}. The hash table returns responses on a response word of the same width.
- The block round-robin arbitrates requests into a registered issue stage, tags each issued command with its requester index in an in-order tag FIFO, and routes table responses back to the originating requester.
- Sits between the client ports and the hash table's packed command/response port.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- KEY_WIDTH, 4, key width.
- DATA_WIDTH, 26, data width.
- MAX_OUTSTANDING, 4, tag FIFO depth; maximum number of issued-but-unanswered commands (power of 2, ≥2).
- Derived values: W = 2+DATA_WIDTH+KEY_WIDTH; IW = clog2(NUM_REQ); CW = clog2(MAX_OUTSTANDING)+1.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_data_i  in  NUM_REQ*W  requester r command word at slice [r*W +: W].
- req_valid_i  in  NUM_REQ  per-requester command valid.
- req_ready_o  out  NUM_REQ  per-requester accept; one-hot or zero.
- rsp_data_o  out  W  response word, broadcast to all requesters.
- rsp_valid_o  out  NUM_REQ  one-hot response valid for the target requester.
- rsp_ready_i  in  NUM_REQ  per-requester response ready.
- tbl_data_o  out  W  command word to the hash table.
- tbl_valid_o  out  1  command valid to the hash table.
- tbl_ready_i  in  1  hash table accepts the command.
- tbl_data_i  in  W  response word from the hash table.
- tbl_valid_i  in  1  response valid from the hash table.
- tbl_ready_o  out  1  arbiter accepts the response.
- orphan_o  out  1  one-cycle pulse: a response arrived with no outstanding tag.

Behaviour:
- **Reset state** (reset=0, async): tbl_valid_o=0, tbl_data_o=0, rr_ptr=0, tag FIFO empty, count=0, orphan_o=0.
  - req_ready_o and rsp_valid_o are 0 during reset because they are decoded from empty state.
- **Issue stage:** one output register {tbl_data_o, tbl_valid_o}.
  - can_accept = (!tbl_valid_o || tbl_ready_i) && (count < MAX_OUTSTANDING).
  - When can_accept is high and any req_valid_i is set, the winner w gets req_ready_o[w]=1 in the same cycle.
  - Next edge: tbl_data_o <= req_data_i[w], tbl_valid_o <= 1, push w into the tag FIFO, rr_ptr <= (w+1) mod NUM_REQ.
  - Otherwise, if tbl_ready_i is high, tbl_valid_o <= 0.
  - tbl_data_o is held stable while tbl_valid_o=1 and tbl_ready_i=0.
  - Latency from request acceptance to tbl_valid_o is 1 cycle. Full throughput is 1 command per cycle.
- **Arbitration:** round-robin. Search req_valid_i starting at index rr_ptr, ascending with wrap; the first set bit wins.
  - rr_ptr changes only on a grant. A requester is never granted twice while another valid requester is waiting.
  - Requesters must hold valid and data stable until ready; the arbiter does not check this.
- **count:** CW-bit counter of issued-and-unanswered commands. It includes the command held in the issue register.
  - +1 on grant, −1 on response handshake; both in the same cycle leave it unchanged.
  - Capacity freed by a response is usable no earlier than the next cycle; there is no pass-through.
- **Response routing:** head = tag FIFO head index.
  - Tags not empty: rsp_valid_o[head] = tbl_valid_i; rsp_data_o = tbl_data_i; tbl_ready_o = rsp_ready_i[head].
  - On tbl_valid_i && tbl_ready_o: pop the tag.
  - Responses return strictly in issue order; the hash table is in-order.
- **Orphan response** (tags empty): tbl_ready_o=1, the response is dropped, rsp_valid_o=0, orphan_o=1 for that cycle.
- **Same-cycle events:** grant, issue-stage drain and response pop may all occur in the same cycle. Push and pop of the FIFO are independent; push writes the tail and pop advances the head.
- **Reset mid-operation:** the outstanding tags are lost. Any later table responses are treated as orphans and flagged.

Optional Feature:
- Macro HT_ARB_PRIORITY_EN.
- When defined: requester 0 has strict priority. If req_valid_i[0] is set and can_accept is high, requester 0 wins regardless of rr_ptr, and rr_ptr is not updated. Requesters 1..NUM_REQ-1 arbitrate round-robin among themselves when requester 0 is idle.
- When undefined: pure round-robin as above, and all requesters are equal.

Test Plan:
- **Single request:** NUM_REQ=4; requester 2 sends op=01, key=5, data=0x123 with tbl_ready_i=1.
  - req_ready_o=0100 in the same cycle; tbl_valid_o=1 next cycle with the same word.
  - A response 3 cycles later appears on rsp_valid_o=0100 with identical data.
- **Fairness:** all 4 requesters valid continuously, table always ready, responses returned promptly.
  - Grant order is 0,1,2,3,0,1,...; each requester gets exactly 25 grants in 100 cycles.
- **Backpressure:** tbl_ready_i=0 for 5 cycles with a command pending.
  - tbl_data_o is stable and req_ready_o=0; after ready rises, the next grant occurs in the same cycle as the drain.
- **Outstanding limit:** MAX_OUTSTANDING=4, no responses returned.
  - Exactly 4 grants occur, then req_ready_o=0 indefinitely.
  - One response pops a tag and allows one more grant starting the following cycle.
- **Response routing:** issue order r3, r1, r3; requester 1 holds rsp_ready_i=0.
  - The second response stalls with tbl_ready_o=0 until rsp_ready_i[1]=1; responses go to 1000, 0010, 1000 in order.
- **Orphan and reset:** reset asserted with 2 tags outstanding, then 2 table responses arrive.
  - Both are dropped with orphan_o pulsing once each, rsp_valid_o=0, count=0.
  - With HT_ARB_PRIORITY_EN defined, requester 0 beats rr_ptr=2.
